// File: rtl/trace_capture_unit.sv
// trace_capture_unit: commit-trace recorder with trigger modes, post-trigger count and oldest-first readout.
// Define TRACE_TIMESTAMP_EN to stamp each entry with a free-running TS_W-bit cycle count.
module trace_capture_unit #(
    parameter int DEPTH = 512,
    parameter int ADDR_W = 9,
    parameter int POST_W = 16,
    parameter int TS_W = 32,
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = 102 + TS_W
`else
    localparam int ENTRY_W = 102 + 0 * TS_W
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic [1:0]         trig_mode,
    input  logic [31:0]        trig_pc,
    input  logic [31:0]        trig_instr,
    input  logic [POST_W-1:0]  post_count,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    input  logic [31:0]        commit_instr,
    input  logic               commit_wen,
    input  logic [4:0]         commit_waddr,
    input  logic [31:0]        commit_wdata,
    output logic [2:0]         state,
    output logic               done,
    output logic               wrapped,
    output logic [ADDR_W:0]    entry_count,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_entry
);
    typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, POST = 3'd2, DONE = 3'd3, READ = 3'd4} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t st, st_n;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] entry;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, raddr;
    logic [ADDR_W:0] rd_cnt, rd_num;
    logic [POST_W-1:0] remaining;
    logic hit, rec, rd_go, rd_last;
    assign hit = (trig_mode == 2'd0) || (trig_mode == 2'd1 && commit_pc == trig_pc) ||
                 (trig_mode == 2'd2 && commit_instr == trig_instr);
    assign rec = !arm && commit_valid && (st == ARMED || st == POST);
    assign rd_go = !arm && rd_req && (st == DONE || st == READ);
    // The first read of a capture starts at the oldest surviving entry.
    assign raddr = st == DONE ? (wrapped ? wr_ptr : '0) : rd_ptr;
    assign rd_num = st == DONE ? (ADDR_W + 1)'(1) : rd_cnt + (ADDR_W + 1)'(1);
    assign rd_last = rd_num == entry_count;
    assign state = st;
    assign done = st == DONE || st == READ;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    always_ff @(posedge clk)
        ts <= reset ? '0 : ts + TS_W'(1);
    assign entry = {ts, commit_pc, commit_instr, commit_wen, commit_waddr, commit_wdata};
`else
    assign entry = {commit_pc, commit_instr, commit_wen, commit_waddr, commit_wdata};
`endif
    always_ff @(posedge clk)
        st <= reset ? IDLE : st_n;
    always_comb begin
        st_n = st;
        if (arm)
            st_n = ARMED;
        else
            case (st)
                ARMED: st_n = rec && hit ? (remaining == '0 ? DONE : POST) : ARMED;
                POST:  st_n = rec && remaining == POST_W'(1) ? DONE : POST;
                DONE:  st_n = rd_go ? (rd_last ? IDLE : READ) : DONE;
                READ:  st_n = rd_go && rd_last ? IDLE : READ;
                default: st_n = IDLE;
            endcase
    end
    always_ff @(posedge clk)
        if (rec)
            mem[wr_ptr] <= entry;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_cnt <= '0;
            entry_count <= '0;
            wrapped <= 1'b0;
            remaining <= '0;
            rd_valid <= 1'b0;
            rd_entry <= '0;
        end else begin
            rd_valid <= rd_go;
            if (arm) begin
                wr_ptr <= '0;
                entry_count <= '0;
                wrapped <= 1'b0;
                remaining <= post_count;
            end else if (rec) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                entry_count <= entry_count + (ADDR_W + 1)'(entry_count != FULL);
                wrapped <= wrapped || wr_ptr == LAST;
                if (st == POST)
                    remaining <= remaining - POST_W'(1);
            end
            if (rd_go) begin
                rd_ptr <= raddr + ADDR_W'(1);
                rd_cnt <= rd_num;
                rd_entry <= mem[raddr];
            end
        end
    end
endmodule

// File: tb/tb_trace_capture_unit.sv
// tb_trace_capture_unit: directed vectors against a queue-based model of the trace capture unit.
module tb_trace_capture_unit;
    localparam int D = 8;
    localparam int AW = 3;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 134;
`else
    localparam int EW = 102;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1, arm = 1'b0, commit_valid = 1'b0, commit_wen = 1'b0, rd_req = 1'b0;
    logic [1:0] trig_mode = 2'd0;
    logic [31:0] trig_pc = '0, trig_instr = '0, commit_pc = '0, commit_instr = '0, commit_wdata = '0;
    logic [15:0] post_count = '0;
    logic [4:0] commit_waddr = '0;
    logic [2:0] state;
    logic done, wrapped, rd_valid;
    logic [AW:0] entry_count;
    logic [EW-1:0] rd_entry;
    int nvec = 0, nerr = 0;
    bit run = 1'b0;
    int ms = 0, mrem = 0, mrec = 0, mrd = 0;
    bit mrv = 1'b0;
    logic [EW-1:0] mre = '0;
    logic [EW-1:0] mq[$];
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] mts = '0;
    logic [31:0] t0, t1;
`endif
    always #5 clk = ~clk;
    trace_capture_unit #(.DEPTH(D), .ADDR_W(AW), .POST_W(16), .TS_W(32)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_instr(trig_instr), .post_count(post_count), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_wen(commit_wen),
        .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .state(state), .done(done),
        .wrapped(wrapped), .entry_count(entry_count), .rd_req(rd_req), .rd_valid(rd_valid),
        .rd_entry(rd_entry)
    );
    task automatic chk(input string nm, input logic [133:0] got, input logic [133:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    function automatic logic [EW-1:0] mk();
`ifdef TRACE_TIMESTAMP_EN
        return {mts, commit_pc, commit_instr, commit_wen, commit_waddr, commit_wdata};
`else
        return {commit_pc, commit_instr, commit_wen, commit_waddr, commit_wdata};
`endif
    endfunction
    task automatic model_step();
        logic [EW-1:0] e = mk();
        bit nrv = 1'b0;
        bit h = trig_mode == 2'd0 || (trig_mode == 2'd1 && commit_pc == trig_pc) ||
                (trig_mode == 2'd2 && commit_instr == trig_instr);
`ifdef TRACE_TIMESTAMP_EN
        mts = reset ? 32'd0 : mts + 32'd1;
`endif
        if (reset) begin
            ms = 0; mq.delete(); mrec = 0; mrv = 1'b0; mre = '0;
            return;
        end
        if (arm) begin
            ms = 1; mq.delete(); mrec = 0; mrem = int'(post_count);
        end else if ((ms == 1 || ms == 2) && commit_valid) begin
            mq.push_back(e);
            mrec++;
            if (mq.size() > D) void'(mq.pop_front());
            if (ms == 1) begin
                if (h) ms = (mrem == 0) ? 3 : 2;
            end else begin
                mrem--;
                if (mrem == 0) ms = 3;
            end
        end else if ((ms == 3 || ms == 4) && rd_req) begin
            if (ms == 3) mrd = 0;
            ms = 4;
            mre = mq[mrd];
            mrd++;
            nrv = 1'b1;
            if (mrd == mq.size()) ms = 0;
        end
        mrv = nrv;
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic cmt(input logic [31:0] pc, input logic [31:0] instr);
        commit_valid = 1'b1;
        commit_pc = pc;
        commit_instr = instr;
        tick();
    endtask
    task automatic start(input logic [1:0] m, input logic [15:0] pcnt);
        trig_mode = m;
        post_count = pcnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask
    always @(negedge clk)
        if (run) begin
            chk("state", state, ms);
            chk("done", done, ms == 3 || ms == 4);
            chk("wrapped", wrapped, mrec >= D);
            chk("entry_count", entry_count, mq.size());
            chk("rd_valid", rd_valid, mrv);
            chk("rd_entry", rd_entry, mre);
        end
    initial begin
        tick();
        run = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset state", state, 0);
        chk("reset count", entry_count, 0);
        start(2'd0, 16'd3);
        chk("t1 armed", state, 1);
        for (int k = 0; k < 5; k++) cmt(32'h00400000 + 4 * k, 32'h13);
        commit_valid = 1'b0;
        chk("t1 count", entry_count, 4);
        chk("t1 wrapped", wrapped, 0);
        chk("t1 done", done, 1);
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1 rd_valid", rd_valid, 1);
            chk("t1 pc", rd_entry[101:70], 32'h00400000 + 4 * i);
        end
        rd_req = 1'b0;
        tick();
        chk("t1 idle", state, 0);
        chk("t1 done low", done, 0);
        trig_pc = 32'h00400040;
        start(2'd1, 16'd2);
        for (int k = 0; k < 20; k++) cmt(32'h00400000 + 4 * k, 32'h13);
        commit_valid = 1'b0;
        chk("t2 wrapped", wrapped, 1);
        chk("t2 count", entry_count, 8);
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2 pc", rd_entry[101:70], 32'h0040002C + 4 * i);
        end
        rd_req = 1'b0;
        tick();
        trig_instr = 32'h0000000C;
        start(2'd2, 16'd0);
        commit_wen = 1'b1; commit_waddr = 5'd2; commit_wdata = 32'h12345678;
        cmt(32'h00400100, 32'h0000000C);
        commit_valid = 1'b0; commit_wen = 1'b0; commit_waddr = '0; commit_wdata = '0;
        chk("t3 done", done, 1);
        chk("t3 count", entry_count, 1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t3 entry", rd_entry[101:0], {32'h00400100, 32'h0000000C, 1'b1, 5'd2, 32'h12345678});
        chk("t3 idle", state, 0);
        start(2'd0, 16'd10);
        for (int k = 0; k < 5; k++) cmt(32'h00000400 + 4 * k, 32'h13);
        chk("t4 post", state, 2);
        post_count = 16'd1;
        arm = 1'b1;
        cmt(32'h00000500, 32'h13);
        arm = 1'b0;
        commit_valid = 1'b0;
        chk("t4 rearmed", state, 1);
        chk("t4 count", entry_count, 0);
        cmt(32'h00000600, 32'h13);
        cmt(32'h00000604, 32'h13);
        commit_valid = 1'b0;
        chk("t4 count2", entry_count, 2);
        rd_req = 1'b1;
        tick();
        chk("t4 first pc", rd_entry[101:70], 32'h00000600);
        tick();
        chk("t4 second pc", rd_entry[101:70], 32'h00000604);
        rd_req = 1'b0;
        tick();
        start(2'd0, 16'd3);
        for (int k = 0; k < 4; k++) cmt(32'h00000700 + 4 * k, 32'h13);
        commit_valid = 1'b0;
        rd_req = 1'b1;
        tick();
        tick();
        chk("t5 reading", state, 4);
        reset = 1'b1;
        tick();
        chk("t5 state", state, 0);
        chk("t5 rd_valid", rd_valid, 0);
        chk("t5 done", done, 0);
        chk("t5 count", entry_count, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("t5 rd ignored", rd_valid, 0);
        start(2'd3, 16'd0);
        for (int k = 0; k < 10; k++) cmt(32'h00000A00 + 4 * k, 32'h13);
        commit_valid = 1'b0;
        chk("t7 armed", state, 1);
        chk("t7 count", entry_count, 8);
        chk("t7 rd_valid", rd_valid, 0);
        rd_req = 1'b0;
        start(2'd0, 16'd10);
        for (int k = 0; k < 12; k++) cmt(32'h00000800 + 4 * k, 32'h13);
        commit_valid = 1'b0;
        chk("t8 done", done, 1);
        rd_req = 1'b1;
        tick();
        chk("t8 oldest pc", rd_entry[101:70], 32'h0000080C);
        repeat (7) tick();
        chk("t8 newest pc", rd_entry[101:70], 32'h00000828);
        rd_req = 1'b0;
        tick();
`ifdef TRACE_TIMESTAMP_EN
        start(2'd0, 16'd1);
        cmt(32'h00000900, 32'h1);
        commit_valid = 1'b0;
        repeat (6) tick();
        cmt(32'h00000904, 32'h2);
        commit_valid = 1'b0;
        rd_req = 1'b1;
        tick();
        t0 = rd_entry[133:102];
        tick();
        t1 = rd_entry[133:102];
        rd_req = 1'b0;
        chk("t6 ts delta", t1 - t0, 7);
        tick();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
